seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised multiplexed 7-segment scan driver, successor to the fixed 6-digit driver in the temperature display path. Time-multiplexes NUM_DIGITS nibble-coded characters onto shared segment lines. Adds frame-atomic input capture, per-digit decimal points, leading-zero blanking, per-digit blink, 16-level PWM brightness and anti-ghosting dead time. Sits between the value formatter and the board digit/segment pins.

## Interface
- NUM_DIGITS, 6: digits scanned; 2..8.
- SCAN_CYCLES, 1000: clk cycles per digit slot (20 us at 50 MHz).
- BLANK_CYCLES, 40: dead time at the start of each slot, all digits off; ≥2.
- DIM_STEP, 60: lit cycles per brightness step; BLANK_CYCLES + 16*DIM_STEP ≤ SCAN_CYCLES.
- BLINK_FRAMES, 50: frames per blink half-period; ≥1.
- SEL_ACTIVE_LOW, 1: polarity of sel.
- SEG_ACTIVE_LOW, 1: polarity of dig, including the decimal point.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dis_data  in  4*NUM_DIGITS  character codes; nibble i drives digit i.
- dp_mask  in  NUM_DIGITS  bit i = 1 lights the decimal point of digit i.
- blink_mask  in  NUM_DIGITS  bit i = 1 blinks digit i.
- brightness  in  4  0 = dimmest lit level, 15 = brightest.
- lzb_en  in  1  enables leading-zero blanking.
- sel  out  NUM_DIGITS  digit enables, one-hot at the active level.
- dig  out  8  {dp, g, f, e, d, c, b, a}.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- Counters: slot_cnt 0..SCAN_CYCLES-1. digit_idx 0..NUM_DIGITS-1 increments when slot_cnt wraps, and wraps to 0 after NUM_DIGITS-1. frame_cnt 0..BLINK_FRAMES-1 increments at each digit_idx wrap and toggles blink_phase when it wraps.
- Frame start is the cycle in which slot_cnt=0 and digit_idx=0. In that cycle dis_data, dp_mask, blink_mask, brightness and lzb_en are captured into snapshot registers. Input changes at any other time have no effect until the next frame.
- Character codes: 0–9 are digits. 0xA is the plus glyph (g,f,e,d lit). 0xB is minus (g lit). 0xC is 'C' (a,f,e,d lit). 0xD–0xF are blank.
- Leading-zero blanking (when the snapshot lzb_en=1): scan from digit NUM_DIGITS-1 down to digit 1. A digit is blanked while its code is 0 and its dp bit is 0. Blanking stops at the first digit that fails that test. Digit 0 is never blanked.
- Blink: when blink_phase=1, digits with a snapshot blink_mask bit set are fully off, including dp.
- Lit window: the selected digit is active iff BLANK_CYCLES ≤ slot_cnt < BLANK_CYCLES + (brightness+1)*DIM_STEP. Outside the window, sel is all-inactive and dig is all-off.
- A blanked or blinked-off digit keeps sel active during the window but drives dig all-off.
- Polarity: the internal encoding is active-high. sel is inverted iff SEL_ACTIVE_LOW; dig is inverted iff SEG_ACTIVE_LOW.

## Timing
- Reset: all counters and snapshot registers go to 0, and blink_phase=0. sel and dig go to the inactive level (all 1 when active-low). frame_start=0.
- The first cycle after rst deasserts is a frame start.
- sel, dig and frame_start are registered. They reflect the counter state of the previous cycle (latency 1).
- frame_start is high in the cycle after the frame-start counter state.
- Snapshot latency: capture at frame start. The first lit cycle using the new values is slot_cnt=BLANK_CYCLES of digit 0. BLANK_CYCLES ≥ 2 guarantees no mixed-frame output.
- At most one sel bit is active in any cycle. Every slot begins with BLANK_CYCLES cycles of all-off.
- Frame period = NUM_DIGITS*SCAN_CYCLES cycles. Blink half-period = BLINK_FRAMES frames.
- rst asserted mid-frame: outputs return to the reset values on the next edge. Scanning restarts at digit 0 with a fresh capture.

## Structure
- Package seg_pkg holds:
  - the glyph constants (ZER..NIN, PLUS, MINUS, LETTER_C, BLANK) as 7-bit active-high gfedcba;
  - the code localparams CODE_PLUS=4'hA, CODE_MINUS=4'hB, CODE_C=4'hC.
- Sub-module seg_glyph_decode: combinational 4-bit code plus dp bit to 8-bit active-high segments. Instantiated once on the selected nibble.
- Top level contains the counters, snapshot registers, blanking logic, window compare, polarity inversion and output registers.

## Test plan
All scenarios use NUM_DIGITS=6, SCAN_CYCLES=20, BLANK_CYCLES=2, DIM_STEP=1, BLINK_FRAMES=2, active-low.
- **Reset and scan:** hold rst 3 cycles, then dis_data=24'h543210, brightness=15 → digit i lit for cycles 2..17 of slot i with its own glyph. sel never has two bits low. Frame period is 120 cycles.
- **Brightness:** brightness=0 → each digit lit exactly 1 cycle per slot (slot_cnt=2). brightness=7 → lit 8 cycles.
- **Leading-zero blanking:** lzb_en=1 with dis_data=24'h000305 → digits 5,4,3 dark and digits 2,1,0 show 3,0,5. Adding dp_mask=6'b001000 → digit 3 shows "0." and digits 5,4 stay dark.
- **Blink:** blink_mask=6'b000001 → digit 0 shows its glyph for 2 frames, is dark for 2 frames, and repeats. Other digits are unaffected.
- **Atomic capture:** change dis_data in the middle of digit 2's slot → no change to displayed digits until the next frame_start. Then all digits update together.
- **Mid-frame reset:** assert rst during digit 4 → next cycle sel=6'h3F and dig=8'hFF. After release, scanning restarts at digit 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared glyph table and character codes for the multiplexed 7-segment scan driver.
package seg_pkg;

  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned CODE_W  = 4;

  // Active-high glyphs, bit order {g, f, e, d, c, b, a}
  localparam logic [GLYPH_W-1:0] ZER      = 7'h3F;
  localparam logic [GLYPH_W-1:0] ONE      = 7'h06;
  localparam logic [GLYPH_W-1:0] TWO      = 7'h5B;
  localparam logic [GLYPH_W-1:0] THR      = 7'h4F;
  localparam logic [GLYPH_W-1:0] FOU      = 7'h66;
  localparam logic [GLYPH_W-1:0] FIV      = 7'h6D;
  localparam logic [GLYPH_W-1:0] SIX      = 7'h7D;
  localparam logic [GLYPH_W-1:0] SEV      = 7'h07;
  localparam logic [GLYPH_W-1:0] EIG      = 7'h7F;
  localparam logic [GLYPH_W-1:0] NIN      = 7'h6F;
  localparam logic [GLYPH_W-1:0] PLUS     = 7'h78;
  localparam logic [GLYPH_W-1:0] MINUS    = 7'h40;
  localparam logic [GLYPH_W-1:0] LETTER_C = 7'h39;
  localparam logic [GLYPH_W-1:0] BLANK    = 7'h00;

  localparam logic [CODE_W-1:0] CODE_PLUS  = 4'hA;
  localparam logic [CODE_W-1:0] CODE_MINUS = 4'hB;
  localparam logic [CODE_W-1:0] CODE_C     = 4'hC;

endpackage

// File: rtl/seg_glyph_decode.sv
// Character code plus decimal point to active-high {dp, g..a} segments.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic              dp_i,
  output logic [7:0]        seg_c_o
);

  // Glyph lookup; codes 0xD..0xF fall through to blank
  always_comb begin
    seg_c_o = {dp_i, BLANK};
    case (code_i)
      4'd0:       seg_c_o = {dp_i, ZER};
      4'd1:       seg_c_o = {dp_i, ONE};
      4'd2:       seg_c_o = {dp_i, TWO};
      4'd3:       seg_c_o = {dp_i, THR};
      4'd4:       seg_c_o = {dp_i, FOU};
      4'd5:       seg_c_o = {dp_i, FIV};
      4'd6:       seg_c_o = {dp_i, SIX};
      4'd7:       seg_c_o = {dp_i, SEV};
      4'd8:       seg_c_o = {dp_i, EIG};
      4'd9:       seg_c_o = {dp_i, NIN};
      CODE_PLUS:  seg_c_o = {dp_i, PLUS};
      CODE_MINUS: seg_c_o = {dp_i, MINUS};
      CODE_C:     seg_c_o = {dp_i, LETTER_C};
      default:    seg_c_o = {dp_i, BLANK};
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan driver with frame-atomic capture, leading-zero
// blanking, per-digit blink, PWM brightness and per-slot dead time.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned SCAN_CYCLES    = 1000,
  parameter int unsigned BLANK_CYCLES   = 40,
  parameter int unsigned DIM_STEP       = 60,
  parameter int unsigned BLINK_FRAMES   = 50,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] dis_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [3:0]              brightness,
  input  logic                    lzb_en,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              dig,
  output logic                    frame_start
);

  localparam int unsigned SW     = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DW     = $clog2(NUM_DIGITS);
  localparam int unsigned FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  logic [SW-1:0]         slot_q, slot_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  blink_phase_q, blink_phase_d;

  logic [DATA_W-1:0]     snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0] snap_blink_q, snap_blink_d;
  logic [3:0]            snap_bright_q, snap_bright_d;
  logic                  snap_lzb_q, snap_lzb_d;

  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            dig_q, dig_d;
  logic                  frame_start_q, frame_start_d;

  logic                  frame_start_c;
  logic [NUM_DIGITS-1:0] lzb_dark_c;
  logic                  lead_c;
  logic [CODE_W-1:0]     cur_code_c;
  logic                  cur_dp_c;
  logic                  cur_dark_c;
  logic [31:0]           lit_end_c;
  logic                  in_window_c;
  logic [7:0]            glyph_c;
  logic [NUM_DIGITS-1:0] sel_on_c;
  logic [7:0]            seg_on_c;

  // Slot / digit / frame counters and blink phase
  always_comb begin
    slot_d        = slot_q + SW'(1);
    digit_d       = digit_q;
    frame_d       = frame_q;
    blink_phase_d = blink_phase_q;
    frame_start_c = (slot_q == '0) && (digit_q == '0);
    if (slot_q == SW'(SCAN_CYCLES - 1)) begin
      slot_d = '0;
      if (digit_q == DW'(NUM_DIGITS - 1)) begin
        digit_d = '0;
        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
          frame_d       = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end else begin
        digit_d = digit_q + DW'(1);
      end
    end
  end

  // Snapshot inputs only at frame start so a frame never mixes old and new values
  always_comb begin
    snap_data_d   = snap_data_q;
    snap_dp_d     = snap_dp_q;
    snap_blink_d  = snap_blink_q;
    snap_bright_d = snap_bright_q;
    snap_lzb_d    = snap_lzb_q;
    if (frame_start_c) begin
      snap_data_d   = dis_data;
      snap_dp_d     = dp_mask;
      snap_blink_d  = blink_mask;
      snap_bright_d = brightness;
      snap_lzb_d    = lzb_en;
    end
  end

  // Leading-zero blanking: walk down from the top digit while code==0 and no dp
  always_comb begin
    lzb_dark_c = '0;
    lead_c     = snap_lzb_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead_c        = lead_c && (snap_data_q[4*i +: 4] == 4'h0) && !snap_dp_q[i];
      lzb_dark_c[i] = lead_c;
    end
  end

  // Pick the scanned digit's code and dark state; evaluate the lit window
  always_comb begin
    cur_code_c = '0;
    cur_dp_c   = 1'b0;
    cur_dark_c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == DW'(i)) begin
        cur_code_c = snap_data_q[4*i +: 4];
        cur_dp_c   = snap_dp_q[i];
        cur_dark_c = lzb_dark_c[i] || (blink_phase_q && snap_blink_q[i]);
      end
    end
    lit_end_c   = 32'(BLANK_CYCLES) + (32'(snap_bright_q) + 32'd1) * 32'(DIM_STEP);
    in_window_c = (32'(slot_q) >= 32'(BLANK_CYCLES)) && (32'(slot_q) < lit_end_c);
  end

  seg_glyph_decode u_decode (
    .code_i  (cur_code_c),
    .dp_i    (cur_dp_c),
    .seg_c_o (glyph_c)
  );

  // Active-high drive, then board polarity
  always_comb begin
    sel_on_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_on_c[i] = in_window_c && (digit_q == DW'(i));
    end
    seg_on_c      = (in_window_c && !cur_dark_c) ? glyph_c : 8'h00;
    sel_d         = SEL_ACTIVE_LOW ? ~sel_on_c : sel_on_c;
    dig_d         = SEG_ACTIVE_LOW ? ~seg_on_c : seg_on_c;
    frame_start_d = frame_start_c;
  end

  // State, snapshot and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      digit_q       <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
      snap_data_q   <= '0;
      snap_dp_q     <= '0;
      snap_blink_q  <= '0;
      snap_bright_q <= '0;
      snap_lzb_q    <= 1'b0;
      sel_q         <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
      dig_q         <= {8{SEG_ACTIVE_LOW}};
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      digit_q       <= digit_d;
      frame_q       <= frame_d;
      blink_phase_q <= blink_phase_d;
      snap_data_q   <= snap_data_d;
      snap_dp_q     <= snap_dp_d;
      snap_blink_q  <= snap_blink_d;
      snap_bright_q <= snap_bright_d;
      snap_lzb_q    <= snap_lzb_d;
      sel_q         <= sel_d;
      dig_q         <= dig_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign dig         = dig_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: randomized inputs against a frame/slot arithmetic model.
module tb_seg_scan_mux;

  localparam int unsigned ND    = 6;
  localparam int unsigned SC    = 20;
  localparam int unsigned BC    = 2;
  localparam int unsigned DS    = 1;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = ND * SC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] dis_data = '0;
  logic [5:0]  dp_mask = '0;
  logic [5:0]  blink_mask = '0;
  logic [3:0]  brightness = '0;
  logic        lzb_en = 1'b0;
  logic [5:0]  sel;
  logic [7:0]  dig;
  logic        frame_start;

  int errs = 0;
  int checks = 0;

  // model state: cycles since reset release plus the values captured at frame start
  int          m_n = 0;
  logic [23:0] m_data = '0;
  logic [5:0]  m_dp = '0, m_blink = '0;
  logic [3:0]  m_br = '0;
  logic        m_lzb = 1'b0;
  logic [5:0]  m_sel;
  logic [7:0]  m_dig;
  logic        m_fs;

  // per-frame observation results
  int          o_mism, o_ghost, o_fs_cnt, o_fs_at, o_first;
  int          o_cnt[ND];
  logic [7:0]  o_dig[ND];

  seg_scan_mux #(
    .NUM_DIGITS(ND), .SCAN_CYCLES(SC), .BLANK_CYCLES(BC), .DIM_STEP(DS),
    .BLINK_FRAMES(BF), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .dis_data(dis_data), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .brightness(brightness), .lzb_en(lzb_en),
    .sel(sel), .dig(dig), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1111000;
      4'hB: return 7'b1000000;
      4'hC: return 7'b0111001;
      default: return 7'b0000000;
    endcase
  endfunction

  // a digit is dark if blinked off, or if it and every digit above it is a plain zero
  function automatic bit digit_dark(input int d, input int fr);
    if (((fr / BF) % 2) == 1 && m_blink[d]) return 1'b1;
    if (m_lzb && d >= 1) begin
      for (int k = d; k < ND; k++)
        if (m_data[4*k +: 4] != 4'h0 || m_dp[k]) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // advance one clock: predict the registered outputs from the pre-edge state
  task automatic tick();
    logic [5:0] s;
    logic [7:0] d;
    logic       fs;
    int w, dg, sl, fr;
    s = 6'h3F; d = 8'hFF; fs = 1'b0;
    if (rst) begin
      m_n = 0; m_data = '0; m_dp = '0; m_blink = '0; m_br = '0; m_lzb = 1'b0;
    end else begin
      w = m_n % FRAME; dg = w / SC; sl = w % SC; fr = m_n / FRAME;
      fs = (w == 0);
      if (sl >= BC && sl < BC + (int'(m_br) + 1) * DS) begin
        s = ~(6'(1) << dg);
        if (!digit_dark(dg, fr)) d = ~{m_dp[dg], glyph(m_data[4*dg +: 4])};
      end
      if (w == 0) begin
        m_data = dis_data; m_dp = dp_mask; m_blink = blink_mask;
        m_br = brightness; m_lzb = lzb_en;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
    m_sel = s; m_dig = d; m_fs = fs;
  endtask

  task automatic sync_frame();
    while ((m_n % FRAME) != 0) tick();
  endtask

  // run one full frame from a frame boundary, gathering what each digit showed
  task automatic observe_frame();
    o_mism = 0; o_ghost = 0; o_fs_cnt = 0; o_fs_at = -1; o_first = -1;
    for (int i = 0; i < ND; i++) begin o_cnt[i] = 0; o_dig[i] = 8'hFF; end
    for (int c = 0; c < FRAME; c++) begin
      tick();
      if ({sel, dig, frame_start} !== {m_sel, m_dig, m_fs}) o_mism++;
      if ($countones(~sel) > 1) o_ghost++;
      if (frame_start === 1'b1) begin
        o_fs_cnt++;
        if (o_fs_at < 0) o_fs_at = c;
      end
      for (int i = 0; i < ND; i++)
        if (sel[i] === 1'b0) begin
          o_cnt[i]++; o_dig[i] = dig;
          if (o_first < 0) o_first = i;
        end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (sel !== 6'h3F) begin errs++; $display("FAIL reset_sel: got %h expected 3f", sel); end
      checks++;
      if (dig !== 8'hFF) begin errs++; $display("FAIL reset_dig: got %h expected ff", dig); end
      checks++;
      if (frame_start !== 1'b0) begin errs++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    end
  endtask

  task automatic test_scan();
    dis_data = 24'h543210; brightness = 4'd15; dp_mask = '0; blink_mask = '0; lzb_en = 1'b0;
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      observe_frame();
      checks++;
      if (o_mism !== 0) begin errs++; $display("FAIL scan_model: %0d mismatching cycles, expected 0", o_mism); end
      checks++;
      if (o_ghost !== 0) begin errs++; $display("FAIL scan_onehot: %0d multi-select cycles, expected 0", o_ghost); end
      checks++;
      if (o_fs_cnt !== 1 || o_fs_at !== 0) begin
        errs++; $display("FAIL scan_period: fs count %0d at %0d, expected 1 at 0", o_fs_cnt, o_fs_at);
      end
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (o_cnt[i] !== 16 || o_dig[i] !== ~{1'b0, glyph(4'(i))}) begin
          errs++; $display("FAIL scan_digit%0d: lit %0d dig %h, expected 16 %h", i, o_cnt[i], o_dig[i], ~{1'b0, glyph(4'(i))});
        end
      end
    end
  endtask

  task automatic test_brightness();
    int br;
    for (int r = 0; r < 5; r++) begin
      br = (r == 0) ? 0 : (r == 1) ? 7 : int'($urandom_range(0, 15));
      brightness = 4'(br);
      dis_data = 24'($urandom);
      sync_frame();
      observe_frame();
      checks++;
      if (o_mism !== 0) begin errs++; $display("FAIL bright_model: br %0d %0d mismatching cycles", br, o_mism); end
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (o_cnt[i] !== br + 1) begin
          errs++; $display("FAIL bright_width: br %0d digit %0d lit %0d expected %0d", br, i, o_cnt[i], br + 1);
        end
      end
    end
  endtask

  task automatic test_lzb();
    logic [7:0] exp_d[ND];
    brightness = 4'd15; dis_data = 24'h000305; dp_mask = 6'b000000; lzb_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (p == 1) dp_mask = 6'b001000;
      exp_d[5] = 8'hFF; exp_d[4] = 8'hFF;
      exp_d[3] = (p == 1) ? 8'h40 : 8'hFF;
      exp_d[2] = 8'hB0; exp_d[1] = 8'hC0; exp_d[0] = 8'h92;
      sync_frame();
      observe_frame();
      checks++;
      if (o_mism !== 0) begin errs++; $display("FAIL lzb_model: %0d mismatching cycles", o_mism); end
      for (int i = 0; i < ND; i++) begin
        checks++;
        if (o_dig[i] !== exp_d[i] || o_cnt[i] !== 16) begin
          errs++; $display("FAIL lzb_digit%0d: dig %h lit %0d, expected %h 16", i, o_dig[i], o_cnt[i], exp_d[i]);
        end
      end
    end
    lzb_en = 1'b0; dp_mask = '0;
  endtask

  task automatic test_blink();
    int fr;
    logic [7:0] e0;
    blink_mask = 6'b000001; dis_data = 24'h987654;
    sync_frame();
    for (int f = 0; f < 6; f++) begin
      fr = m_n / FRAME;
      observe_frame();
      e0 = (((fr / 2) % 2) == 1) ? 8'hFF : ~{1'b0, glyph(4'h4)};
      checks++;
      if (o_mism !== 0) begin errs++; $display("FAIL blink_model: frame %0d %0d mismatching cycles", fr, o_mism); end
      checks++;
      if (o_dig[0] !== e0 || o_cnt[0] !== 16) begin
        errs++; $display("FAIL blink_d0: frame %0d dig %h lit %0d, expected %h 16", fr, o_dig[0], o_cnt[0], e0);
      end
      checks++;
      if (o_dig[1] !== ~{1'b0, glyph(4'h5)}) begin
        errs++; $display("FAIL blink_d1: frame %0d dig %h expected %h", fr, o_dig[1], ~{1'b0, glyph(4'h5)});
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_atomic();
    logic [23:0] a, b;
    logic [7:0]  seen[ND];
    int mism;
    a = 24'h123456; b = 24'hABC987;
    dis_data = a;
    sync_frame();
    observe_frame();
    mism = 0;
    for (int i = 0; i < ND; i++) seen[i] = 8'h00;
    for (int c = 0; c < FRAME; c++) begin
      if (c == 2 * SC + 10) dis_data = b;
      tick();
      if ({sel, dig, frame_start} !== {m_sel, m_dig, m_fs}) mism++;
      for (int i = 0; i < ND; i++) if (sel[i] === 1'b0) seen[i] = dig;
    end
    checks++;
    if (mism !== 0) begin errs++; $display("FAIL atomic_model: %0d mismatching cycles", mism); end
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (seen[i] !== ~{1'b0, glyph(a[4*i +: 4])}) begin
        errs++; $display("FAIL atomic_old%0d: dig %h expected %h", i, seen[i], ~{1'b0, glyph(a[4*i +: 4])});
      end
    end
    observe_frame();
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (o_dig[i] !== ~{1'b0, glyph(b[4*i +: 4])}) begin
        errs++; $display("FAIL atomic_new%0d: dig %h expected %h", i, o_dig[i], ~{1'b0, glyph(b[4*i +: 4])});
      end
    end
  endtask

  task automatic test_mid_reset();
    dis_data = 24'h765432;
    sync_frame();
    while ((m_n % FRAME) != 4 * SC + 5) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (sel !== 6'h3F || dig !== 8'hFF || frame_start !== 1'b0) begin
      errs++; $display("FAIL midrst_out: sel %h dig %h fs %b, expected 3f ff 0", sel, dig, frame_start);
    end
    rst = 1'b0;
    observe_frame();
    checks++;
    if (o_fs_at !== 0 || o_first !== 0) begin
      errs++; $display("FAIL midrst_restart: fs at %0d first digit %0d, expected 0 0", o_fs_at, o_first);
    end
    checks++;
    if (o_mism !== 0) begin errs++; $display("FAIL midrst_model: %0d mismatching cycles", o_mism); end
  endtask

  task automatic test_random();
    int mism;
    mism = 0;
    for (int c = 0; c < 6 * FRAME; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        dis_data   = 24'($urandom) >> (4 * $urandom_range(0, 5));
        dp_mask    = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
        blink_mask = 6'($urandom);
        brightness = 4'($urandom);
        lzb_en     = 1'($urandom);
      end
      tick();
      if ({sel, dig, frame_start} !== {m_sel, m_dig, m_fs}) mism++;
    end
    checks++;
    if (mism !== 0) begin errs++; $display("FAIL random_model: %0d mismatching cycles, expected 0", mism); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_lzb();
    test_blink();
    test_atomic();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
